axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, AXI data width in bits, a power of two and at least 8.
REQ-004 SHALL have parameter MEM_WORDS, default 1024, memory depth in DATA_WIDTH words, a power of two.
REQ-005 SHALL have port ACLK, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port ARESETn, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 SHALL have port from_master, axi_interface.slave modport, AXI4 responder end; it drives AWREADY, WREADY, BVALID/BID/BRESP, ARREADY and RVALID/RDATA/RLAST/RID/RRESP.

Function
REQ-008 SHALL hold an internal memory of MEM_WORDS x DATA_WIDTH, indexed as word = (addr >> log2(DATA_WIDTH/8)) mod MEM_WORDS.
REQ-009 SHALL run the read and write paths as independent FSMs; both may be busy in the same cycle.
REQ-010 Write FSM SHALL use W_IDLE (AWREADY=1), W_DATA (WREADY=1) and W_RESP (BVALID=1); exactly one READY/VALID is asserted per state.
REQ-011 On an AW handshake, the block SHALL latch AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clear the beat count and enter W_DATA on the next cycle.
REQ-012 On each W handshake, the block SHALL write the WDATA bytes whose WSTRB bit is 1 and leave the other bytes unchanged.
REQ-013 After each beat, INCR SHALL add 2^AWSIZE bytes to the address and FIXED SHALL keep it unchanged.
REQ-014 On the beat where count equals AWLEN, the block SHALL enter W_RESP, ending the burst on count alone and not on WLAST.
REQ-015 BRESP SHALL be SLVERR (2'b10) if any WLAST value disagreed with the count, if AWBURST=WRAP, or if AWSIZE > log2(DATA_WIDTH/8); otherwise OKAY; WRAP or oversize bursts SHALL consume all beats without writing.
REQ-016 BID SHALL equal the latched AWID; the block SHALL hold BVALID until BREADY, then return to W_IDLE on the next cycle.
REQ-017 Read FSM SHALL use R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-018 After an AR handshake in cycle n, the first RVALID SHALL appear in cycle n+1 with registered memory data.
REQ-019 RDATA/RID/RRESP/RLAST SHALL remain stable while RVALID=1 and RREADY=0.
REQ-020 On each R handshake, the block SHALL advance the address using the REQ-013 rules and present the next beat in the following cycle, with no bubble while RREADY stays 1.
REQ-021 RLAST SHALL be 1 only on beat ARLEN; after the RLAST handshake the FSM SHALL return to R_IDLE, with ARREADY=1 in the next cycle.
REQ-022 RRESP SHALL be SLVERR for WRAP or oversize ARSIZE, with RDATA=0 on those beats; otherwise OKAY.
REQ-023 When a write and a read hit the same word in the same cycle, the read SHALL return the old data.
REQ-024 A 256-beat burst (LEN=255) SHALL be supported; the beat counter SHALL be 8 bits and SHALL not wrap mid-burst.

Reset
REQ-025 While ARESETn=0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, BID, RID and RDATA SHALL all be 0 and both FSMs SHALL be in IDLE.
REQ-026 Reset asserted mid-burst SHALL abort the burst without a response and keep writes already committed.
REQ-027 Memory contents SHALL not be reset.
REQ-028 AWREADY and ARREADY SHALL assert in the first cycle after ARESETn deasserts.

Configuration
REQ-029 With macro AXI_RAM_SLAVE_BOUNDS_CHECK_EN defined, any beat whose byte address is at or beyond MEM_WORDS*DATA_WIDTH/8 SHALL return DECERR (2'b11), SHALL not write, and SHALL read 0; BRESP SHALL take DECERR priority over SLVERR.
REQ-030 Without AXI_RAM_SLAVE_BOUNDS_CHECK_EN, addresses SHALL wrap modulo the memory size and return OKAY.

Structure
REQ-031 Package axi_ram_slave_pkg SHALL hold the burst encodings (FIXED=0, INCR=1, WRAP=2), response encodings (OKAY, SLVERR, DECERR) and the write and read FSM state enums.
REQ-032 Sub-module axi_ram_slave_addr_gen (next-address and bounds logic) SHALL be instantiated once per path.

Verification
REQ-033 Single write AW addr 0x10, LEN=0, SIZE=3, WSTRB=0xFF, WDATA=0x1122334455667788 -> BRESP=OKAY, BID echoed; read of 0x10 returns the same data with RLAST=1.
REQ-034 INCR write of 4 beats from 0x0, LEN=3, data 1..4; read with RREADY toggling 1,0,1,0 -> RDATA sequence 1,2,3,4 held stable on stalls, RLAST only on the 4th beat.
REQ-035 WSTRB=0x0F writing 0xFFFFFFFFFFFFFFFF over 0 -> readback 0x00000000FFFFFFFF.
REQ-036 Burst LEN=1 with WLAST=1 on the first beat -> two beats accepted and BRESP=SLVERR; AWBURST=WRAP -> SLVERR and memory unchanged.
REQ-037 Read at 8*MEM_WORDS -> RRESP=DECERR and RDATA=0 with the macro defined; without it, data from word 0 and OKAY.
REQ-038 ARESETn pulsed low during beat 2 of a LEN=7 read -> RVALID=0 at once, ARREADY=1 after release, beats 0-1 of the aborted write still present.

Source files
------------

// File: rtl/axi_ram_slave_pkg.sv
// axi_ram_slave_pkg: burst/response encodings and FSM states shared by the AXI RAM responder.
package axi_ram_slave_pkg;
    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_t;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_interface.sv
// axi_interface: AXI4 bundle with responder (slave) and requester (master) views.
interface axi_interface #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_ram_slave_addr_gen.sv
// axi_ram_slave_addr_gen: per-beat word index, next address and error flags for one burst path.
// AXI_RAM_SLAVE_BOUNDS_CHECK_EN flags beats beyond the memory as decode errors; otherwise addresses wrap.
module axi_ram_slave_addr_gen
    import axi_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [ADDR_WIDTH-1:0]        next_addr,
    output logic [$clog2(MEM_WORDS)-1:0] idx,
    output logic                         slverr,
    output logic                         decerr
);
    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    localparam int WB   = $clog2(MEM_WORDS);
    assign next_addr = burst == BURST_INCR ? addr + (ADDR_WIDTH'(1) << size) : addr;
    assign idx       = addr[OFFS +: WB];
    assign slverr    = burst == BURST_WRAP || int'(size) > OFFS;
`ifdef AXI_RAM_SLAVE_BOUNDS_CHECK_EN
    assign decerr = |(addr >> (OFFS + WB));
`else
    assign decerr = 1'b0;
`endif
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 RAM responder with independent write and read burst FSMs.
// Define AXI_RAM_SLAVE_BOUNDS_CHECK_EN to answer out-of-range beats with DECERR instead of wrapping.
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input logic        ACLK,
    input logic        ARESETn,
    axi_interface.slave from_master
);
    localparam int WB = $clog2(MEM_WORDS);
    localparam int SW = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state;
    logic                  awready, wready, bvalid;
    logic [1:0]            bresp;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_last_err, w_dec_seen;
    logic [WB-1:0]         w_idx;
    logic                  w_slverr, w_decerr, w_beat, w_final;

    r_state_t              r_state;
    logic                  arready, rvalid, rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata, r_word;
    logic [1:0]            rresp, r_resp;
    logic [ADDR_WIDTH-1:0] r_addr, r_next;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [WB-1:0]         r_idx;
    logic                  r_slverr, r_decerr;

    axi_ram_slave_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_w_gen (
        .addr      (w_addr),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next),
        .idx       (w_idx),
        .slverr    (w_slverr),
        .decerr    (w_decerr)
    );

    // In idle the read path evaluates the incoming AR so the first beat is fetched on the handshake edge.
    axi_ram_slave_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_r_gen (
        .addr      (r_state == R_IDLE ? from_master.araddr : r_addr),
        .size      (r_state == R_IDLE ? from_master.arsize : r_size),
        .burst     (r_state == R_IDLE ? from_master.arburst : r_burst),
        .next_addr (r_next),
        .idx       (r_idx),
        .slverr    (r_slverr),
        .decerr    (r_decerr)
    );

    assign w_beat  = wready && from_master.wvalid;
    assign w_final = w_cnt == w_len;
    assign r_word  = r_slverr || r_decerr ? '0 : mem[r_idx];
    assign r_resp  = r_decerr ? RESP_DECERR : r_slverr ? RESP_SLVERR : RESP_OKAY;

    // Burst length is governed by the beat count; WLAST only feeds the error flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state    <= W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            w_id       <= '0;
            w_addr     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            w_last_err <= 1'b0;
            w_dec_seen <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awready && from_master.awvalid) begin
                        w_id       <= from_master.awid;
                        w_addr     <= from_master.awaddr;
                        w_len      <= from_master.awlen;
                        w_size     <= from_master.awsize;
                        w_burst    <= from_master.awburst;
                        w_cnt      <= '0;
                        w_last_err <= 1'b0;
                        w_dec_seen <= 1'b0;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr     <= w_next;
                        w_cnt      <= w_cnt + 8'd1;
                        w_last_err <= w_last_err | (from_master.wlast != w_final);
                        w_dec_seen <= w_dec_seen | w_decerr;
                        if (w_final) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                            bresp   <= w_dec_seen || w_decerr ? RESP_DECERR :
                                       w_slverr || w_last_err || !from_master.wlast ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: begin
                    if (from_master.bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        for (int b = 0; b < SW; b++)
            if (w_beat && !w_slverr && !w_decerr && from_master.wstrb[b])
                mem[w_idx][8*b +: 8] <= from_master.wdata[8*b +: 8];
    end

    // The read beat is fetched from memory on the same edge a write may land, so it sees the old word.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arready && from_master.arvalid) begin
                        r_len   <= from_master.arlen;
                        r_size  <= from_master.arsize;
                        r_burst <= from_master.arburst;
                        rid     <= from_master.arid;
                        r_cnt   <= '0;
                        r_addr  <= r_next;
                        rdata   <= r_word;
                        rresp   <= r_resp;
                        rlast   <= from_master.arlen == 8'd0;
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                default: begin
                    if (from_master.rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt  <= r_cnt + 8'd1;
                            r_addr <= r_next;
                            rdata  <= r_word;
                            rresp  <= r_resp;
                            rlast  <= (r_cnt + 8'd1) == r_len;
                        end
                    end
                end
            endcase
        end
    end

    assign from_master.awready = awready;
    assign from_master.wready  = wready;
    assign from_master.bvalid  = bvalid;
    assign from_master.bresp   = bresp;
    assign from_master.bid     = w_id;
    assign from_master.arready = arready;
    assign from_master.rvalid  = rvalid;
    assign from_master.rlast   = rlast;
    assign from_master.rid     = rid;
    assign from_master.rdata   = rdata;
    assign from_master.rresp   = rresp;
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: self-checking bench for axi_ram_slave against a byte-array memory model.
module tb_axi_ram_slave;
    localparam int IW  = 4;
    localparam int MW  = 1024;
    localparam int NB  = MW * 8;
    localparam int TMO = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0]  mb    [NB];
    logic [63:0] wd    [256];
    logic [7:0]  wsb   [256];
    logic [63:0] er_d  [256];
    logic [1:0]  er_r  [256];
    logic [63:0] got_d [256];

    axi_interface #(.ID_WIDTH(IW), .ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_ram_slave #(
        .ID_WIDTH   (IW),
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MEM_WORDS  (MW)
    ) dut (
        .ACLK        (clk),
        .ARESETn     (rst_n),
        .from_master (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm, input int t);
        if (t >= TMO) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timed out after %0d cycles", nm, t);
        end
    endtask

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int i, input logic [2:0] s, input logic [1:0] bu);
        return bu == 2'd0 ? a : a + 64'(i) * (64'd1 << s);
    endfunction

    function automatic int byte_idx(input logic [63:0] a, input int b);
        return int'((a >> 3) % 64'(MW)) * 8 + b;
    endfunction

    function automatic logic [1:0] model_write(input logic [63:0] addr, input int len, input logic [2:0] s, input logic [1:0] bu, input int lastbeat);
        logic dec = 1'b0;
        logic nowr = bu == 2'd2 || s > 3'd3;
        for (int i = 0; i <= len; i++) begin
            logic [63:0] a = beat_addr(addr, i, s, bu);
            logic oob = 1'b0;
`ifdef AXI_RAM_SLAVE_BOUNDS_CHECK_EN
            oob = a >= 64'(NB);
`endif
            dec |= oob;
            if (!nowr && !oob)
                for (int b = 0; b < 8; b++)
                    if (wsb[i][b]) mb[byte_idx(a, b)] = wd[i][8*b +: 8];
        end
        return dec ? 2'b11 : (nowr || lastbeat != len) ? 2'b10 : 2'b00;
    endfunction

    function automatic void model_read(input logic [63:0] addr, input int len, input logic [2:0] s, input logic [1:0] bu);
        for (int i = 0; i <= len; i++) begin
            logic [63:0] a = beat_addr(addr, i, s, bu);
            er_d[i] = '0;
            er_r[i] = (bu == 2'd2 || s > 3'd3) ? 2'b10 : 2'b00;
`ifdef AXI_RAM_SLAVE_BOUNDS_CHECK_EN
            if (a >= 64'(NB)) er_r[i] = 2'b11;
`endif
            if (er_r[i] == 2'b00)
                for (int b = 0; b < 8; b++) er_d[i][8*b +: 8] = mb[byte_idx(a, b)];
        end
    endfunction

    task automatic idle_bus();
        bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.rready = 0;
    endtask

    task automatic send_aw(input logic [IW-1:0] id, input logic [63:0] addr, input int len, input logic [2:0] s, input logic [1:0] bu);
        int t = 0;
        bus.awvalid = 1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = s; bus.awburst = bu;
        while (!bus.awready && t < TMO) begin @(negedge clk); t++; end
        tmo("aw_wait", t);
        @(negedge clk);
        bus.awvalid = 0;
    endtask

    task automatic send_w(input int i, input logic last);
        int t = 0;
        bus.wvalid = 1; bus.wdata = wd[i]; bus.wstrb = wsb[i]; bus.wlast = last;
        while (!bus.wready && t < TMO) begin @(negedge clk); t++; end
        tmo("w_wait", t);
        @(negedge clk);
        bus.wvalid = 0; bus.wlast = 0;
    endtask

    task automatic send_ar(input logic [IW-1:0] id, input logic [63:0] addr, input int len, input logic [2:0] s, input logic [1:0] bu);
        int t = 0;
        bus.arvalid = 1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = s; bus.arburst = bu;
        while (!bus.arready && t < TMO) begin @(negedge clk); t++; end
        tmo("ar_wait", t);
        @(negedge clk);
        bus.arvalid = 0;
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [63:0] addr, input int len, input logic [2:0] s,
                            input logic [1:0] bu, input int lastbeat, input logic [1:0] exp_resp);
        int t = 0;
        send_aw(id, addr, len, s, bu);
        for (int i = 0; i <= len; i++) send_w(i, i == lastbeat);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        while (!bus.bvalid && t < TMO) begin @(negedge clk); t++; end
        tmo("b_wait", t);
        bus.bready = 1;
        chk("bresp", bus.bresp, exp_resp);
        chk("bid", bus.bid, id);
        @(negedge clk);
        bus.bready = 0;
        chk("bvalid_drop", bus.bvalid, 0);
    endtask

    // mode 0: RREADY held high, 1: toggles 1,0,1,0..., 2: random
    task automatic do_read(input logic [IW-1:0] id, input logic [63:0] addr, input int len, input logic [2:0] s,
                           input logic [1:0] bu, input int mode);
        int i = 0, k = 0;
        model_read(addr, len, s, bu);
        send_ar(id, addr, len, s, bu);
        chk("r_first_valid", bus.rvalid, 1);
        while (i <= len && k < TMO) begin
            bus.rready = mode == 0 ? 1'b1 : mode == 1 ? k % 2 == 0 : 1'($urandom_range(0, 1));
            chk($sformatf("rvalid[%0d]", i), bus.rvalid, 1);
            if (bus.rvalid) begin
                chk($sformatf("rdata[%0d]", i), bus.rdata, er_d[i]);
                chk($sformatf("rresp[%0d]", i), bus.rresp, er_r[i]);
                chk($sformatf("rlast[%0d]", i), bus.rlast, i == len);
                chk($sformatf("rid[%0d]", i), bus.rid, id);
                if (bus.rready) begin got_d[i] = bus.rdata; i++; end
            end
            k++;
            @(negedge clk);
        end
        bus.rready = 0;
        tmo("r_burst", k);
        chk("r_done_arready", bus.arready, 1);
    endtask

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [1:0]  exp_b;
        logic [63:0] exp_r;
    } vec_t;

    vec_t tbl [7];
    logic [1:0] eb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64'h10, 64'h1122334455667788, 8'hFF, 2'd1, 3'd3, 2'b00, 64'h1122334455667788};
        tbl[1] = '{64'h18, 64'h0,                8'hFF, 2'd1, 3'd3, 2'b00, 64'h0};
        tbl[2] = '{64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'd1, 3'd3, 2'b00, 64'h00000000FFFFFFFF};
        tbl[3] = '{64'h10, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'd2, 3'd3, 2'b10, 64'h1122334455667788};
        tbl[4] = '{64'h10, 64'hCAFEF00DCAFEF00D, 8'hFF, 2'd1, 3'd4, 2'b10, 64'h1122334455667788};
        tbl[5] = '{64'h28, 64'hA5A5A5A5A5A5A5A5, 8'h3C, 2'd0, 3'd3, 2'b00, 64'h0000A5A5A5A50000};
        tbl[6] = '{64'h30, 64'h0123456789ABCDEF, 8'hF0, 2'd0, 3'd2, 2'b00, 64'h0123456700000000};
        for (int i = 0; i < NB; i++) mb[i] = 8'h00;
        idle_bus();
        #2 rst_n = 0;
        @(negedge clk);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_resp", {bus.bresp, bus.rresp}, 0);
        chk("rst_ids", {bus.bid, bus.rid}, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_awready", bus.awready, 1);
        chk("post_rst_arready", bus.arready, 1);

        // Clear the whole memory with 256-beat bursts.
        for (int i = 0; i < 256; i++) begin wd[i] = '0; wsb[i] = 8'hFF; end
        for (int q = 0; q < 4; q++) begin
            eb = model_write(64'(q * 2048), 255, 3'd3, 2'd1, 255);
            do_write(IW'(q), 64'(q * 2048), 255, 3'd3, 2'd1, 255, eb);
        end
        do_read(4'h3, 64'd6144, 255, 3'd3, 2'd1, 0);

        for (int v = 0; v < 7; v++) begin
            wd[0] = tbl[v].data; wsb[0] = tbl[v].strb;
            eb = model_write(tbl[v].addr, 0, tbl[v].size, tbl[v].burst, 0);
            do_write(IW'(v + 1), tbl[v].addr, 0, tbl[v].size, tbl[v].burst, 0, tbl[v].exp_b);
            do_read(IW'(v), tbl[v].addr & ~64'h7, 0, 3'd3, 2'd1, 0);
            chk($sformatf("tbl%0d_rdata", v), got_d[0], tbl[v].exp_r);
        end

        // 4-beat INCR burst read back with a stalling master.
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); wsb[i] = 8'hFF; end
        eb = model_write(64'h0, 3, 3'd3, 2'd1, 3);
        do_write(4'h5, 64'h0, 3, 3'd3, 2'd1, 3, 2'b00);
        do_read(4'h6, 64'h0, 3, 3'd3, 2'd1, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("incr4_beat%0d", i), got_d[i], 64'(i + 1));

        // Early WLAST: both beats still accepted, error reported.
        for (int i = 0; i < 2; i++) begin wd[i] = 64'hBEEF0000 + 64'(i); wsb[i] = 8'hFF; end
        eb = model_write(64'h40, 1, 3'd3, 2'd1, 0);
        do_write(4'h7, 64'h40, 1, 3'd3, 2'd1, 0, 2'b10);
        do_read(4'h7, 64'h40, 1, 3'd3, 2'd1, 2);

        // Address just past the memory: wraps to word 0 or decodes as an error.
        do_read(4'h8, 64'(NB), 0, 3'd3, 2'd1, 0);
`ifdef AXI_RAM_SLAVE_BOUNDS_CHECK_EN
        chk("oob_rdata", got_d[0], 64'h0);
`else
        chk("oob_rdata", got_d[0], 64'h1);
`endif

        // Write and read bursts in flight together on disjoint regions.
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; wsb[i] = 8'hFF; end
        eb = model_write(64'h1000, 7, 3'd3, 2'd1, 7);
        fork
            do_write(4'h9, 64'h1000, 7, 3'd3, 2'd1, 7, eb);
            do_read(4'hA, 64'h400, 7, 3'd3, 2'd1, 2);
        join

        // Reset in the middle of a write and a read burst.
        for (int i = 0; i < 8; i++) begin wd[i] = 64'h3000 + 64'(i); wsb[i] = 8'hFF; end
        eb = model_write(64'h300, 7, 3'd3, 2'd1, 7);
        do_write(4'h1, 64'h300, 7, 3'd3, 2'd1, 7, eb);
        for (int i = 0; i < 8; i++) wd[i] = 64'hAB00 + 64'(i);
        send_aw(4'h2, 64'h200, 7, 3'd3, 2'd1);
        send_w(0, 1'b0);
        send_w(1, 1'b0);
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 8; b++) mb[byte_idx(64'h200 + 64'(8 * i), b)] = wd[i][8*b +: 8];
        send_ar(4'h3, 64'h300, 7, 3'd3, 2'd1);
        bus.rready = 1;
        repeat (2) @(negedge clk);
        chk("pre_rst_beat2", bus.rdata, 64'h3002);
        bus.rready = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_rvalid", bus.rvalid, 0);
        chk("mid_rst_rdata", bus.rdata, 0);
        chk("mid_rst_wready", bus.wready, 0);
        chk("mid_rst_arready", bus.arready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rel_arready", bus.arready, 1);
        chk("rel_awready", bus.awready, 1);
        chk("rel_bvalid", bus.bvalid, 0);
        do_read(4'h4, 64'h200, 2, 3'd3, 2'd1, 0);
        chk("abort_beat0", got_d[0], 64'hAB00);
        chk("abort_beat1", got_d[1], 64'hAB01);

        // Random bursts checked against the byte model.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a = 64'($urandom_range(0, NB + 1023));
            int len = $urandom_range(0, 15);
            logic [2:0] s = $urandom_range(0, 9) == 0 ? 3'd4 : 3'($urandom_range(0, 3));
            logic [1:0] bu = 2'($urandom_range(0, 2));
            int lb = $urandom_range(0, 4) == 0 ? $urandom_range(0, len) : len;
            logic [IW-1:0] id = IW'($urandom);
            for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; wsb[i] = 8'($urandom); end
            eb = model_write(a, len, s, bu, lb);
            do_write(id, a, len, s, bu, lb, eb);
            do_read(~id, a, len, s, bu, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
